// File: rtl/multi_tick_divider.sv
// Multi-channel programmable tick divider: each channel emits a one-cycle tick
// every cfg_div clocks (continuous or one-shot) plus a square wave toggled per tick.
module multi_tick_divider #(
    parameter int NCH   = 4,
    parameter int WIDTH = 26,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic             cfg_oneshot,
    output logic             cfg_err,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   wave,
    output logic [NCH-1:0]   busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state [NCH];
    logic [WIDTH-1:0] cnt   [NCH];
    logic [WIDTH-1:0] div_q [NCH];
    logic [NCH-1:0]   mode;
    logic             hold;
    logic             xfer;
    logic             ch_ok;
    logic             div_zero;

    // hold blocks the cycle after every transfer, so accepted configs are spaced by two
    assign cfg_ready = !clr && !hold;
    assign xfer      = cfg_valid && cfg_ready;
    assign ch_ok     = 32'(cfg_ch) < 32'(NCH);
    assign div_zero  = (cfg_div == '0);

    for (genvar g = 0; g < NCH; g++) begin : g_busy
        assign busy[g] = (state[g] == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold    <= 1'b0;
            cfg_err <= 1'b0;
            tick    <= '0;
            wave    <= '0;
            mode    <= '0;
            for (int i = 0; i < NCH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                div_q[i] <= '0;
            end
        end else begin
            hold    <= xfer;
            cfg_err <= xfer && (!ch_ok || (cfg_en && div_zero));
            for (int i = 0; i < NCH; i++) begin
                if (clr) begin
                    state[i] <= IDLE;
                    cnt[i]   <= '0;
                    tick[i]  <= 1'b0;
                    wave[i]  <= 1'b0;
                end else if (xfer && ch_ok && (32'(cfg_ch) == 32'(i))) begin
                    // (re)load restarts the period; never ticks on the load edge
                    cnt[i]   <= '0;
                    div_q[i] <= cfg_div;
                    mode[i]  <= cfg_oneshot;
                    wave[i]  <= 1'b0;
                    tick[i]  <= 1'b0;
                    state[i] <= (cfg_en && !div_zero) ? RUN : IDLE;
                end else if (state[i] == RUN) begin
                    if (cnt[i] == div_q[i] - WIDTH'(1)) begin
                        tick[i] <= 1'b1;
                        wave[i] <= ~wave[i];
                        cnt[i]  <= '0;
                        if (mode[i]) begin
                            state[i] <= IDLE;
                        end
                    end else begin
                        tick[i] <= 1'b0;
                        cnt[i]  <= cnt[i] + WIDTH'(1);
                    end
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Bench for multi_tick_divider: directed scenarios plus randomized traffic checked
// against an absolute-time tick schedule model.
module tb_multi_tick_divider;

    localparam int NCH   = 4;
    localparam int WIDTH = 26;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_en;
    logic             cfg_oneshot;
    logic             cfg_err;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   wave;
    logic [NCH-1:0]   busy;

    int checks = 0;
    int errors = 0;

    // model: per channel, whether running, its period and the absolute edge of its next tick
    logic [NCH-1:0] m_run, m_tick, m_wave, m_os;
    int             m_period [NCH];
    int             m_next   [NCH];
    logic           m_hold, m_err;
    int             e_cnt = 0;

    multi_tick_divider #(.NCH(NCH), .WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_en(cfg_en), .cfg_oneshot(cfg_oneshot),
        .cfg_err(cfg_err), .tick(tick), .wave(wave), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic reset_model();
        m_run  = '0;
        m_tick = '0;
        m_wave = '0;
        m_os   = '0;
        m_hold = 1'b0;
        m_err  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_period[i] = 0;
            m_next[i]   = 0;
        end
    endtask

    task automatic set_cfg(input int ch, input int dv, input bit en, input bit os);
        cfg_valid   = 1'b1;
        cfg_ch      = CW'(ch);
        cfg_div     = WIDTH'(dv);
        cfg_en      = en;
        cfg_oneshot = os;
    endtask

    task automatic idle();
        cfg_valid   = 1'b0;
        cfg_ch      = '0;
        cfg_div     = '0;
        cfg_en      = 1'b0;
        cfg_oneshot = 1'b0;
    endtask

    // advance the model over one edge using the current inputs, then clock the DUT
    task automatic step();
        logic x;
        x = cfg_valid && !clr && !m_hold;
        e_cnt++;
        m_tick = '0;
        for (int i = 0; i < NCH; i++) begin
            if (clr) begin
                m_run[i]  = 1'b0;
                m_wave[i] = 1'b0;
            end else if (x && int'(cfg_ch) == i) begin
                m_run[i]    = cfg_en && (cfg_div != 0);
                m_period[i] = int'(cfg_div);
                m_os[i]     = cfg_oneshot;
                m_wave[i]   = 1'b0;
                m_next[i]   = e_cnt + int'(cfg_div);
            end else if (m_run[i] && e_cnt == m_next[i]) begin
                m_tick[i] = 1'b1;
                m_wave[i] = ~m_wave[i];
                if (m_os[i]) m_run[i] = 1'b0;
                else m_next[i] = m_next[i] + m_period[i];
            end
        end
        m_err  = x && (int'(cfg_ch) >= NCH || (cfg_en && cfg_div == 0));
        m_hold = x;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        idle();
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({tick, wave, busy, cfg_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {tick, wave, busy, cfg_err});
        end
        rst = 1'b0;
        step();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", cfg_ready);
        end
    endtask

    task automatic test_continuous();
        set_cfg(0, 5, 1'b1, 1'b0);
        step();
        idle();
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (tick[0] !== (k % 5 == 0) || wave[0] !== ((k / 5) % 2 == 1) || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL continuous k=%0d got t%b w%b b%b exp t%b w%b b1", k, tick[0], wave[0],
                         busy[0], (k % 5 == 0), ((k / 5) % 2 == 1));
            end
        end
    endtask

    task automatic test_oneshot();
        set_cfg(2, 3, 1'b1, 1'b1);
        step();
        idle();
        for (int k = 1; k <= 23; k++) begin
            step();
            checks++;
            if (tick[2] !== (k == 3) || wave[2] !== (k >= 3) || busy[2] !== (k < 3)) begin
                errors++;
                $display("FAIL oneshot k=%0d got t%b w%b b%b exp t%b w%b b%b", k, tick[2], wave[2],
                         busy[2], (k == 3), (k >= 3), (k < 3));
            end
        end
    endtask

    task automatic test_reconfig();
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_cfg(0, 7, 1'b1, 1'b0);
        step();
        idle();
        step();
        set_cfg(1, 4, 1'b1, 1'b0);
        step();
        idle();
        for (int k = 1; k <= 14; k++) begin
            if (k == 6) set_cfg(1, 2, 1'b1, 1'b0);
            step();
            idle();
            checks++;
            if (tick[1] !== (k == 4 || (k >= 8 && k % 2 == 0)) || tick[0] !== (k == 5 || k == 12)) begin
                errors++;
                $display("FAIL reconfig k=%0d got t1=%b t0=%b exp t1=%b t0=%b", k, tick[1], tick[0],
                         (k == 4 || (k >= 8 && k % 2 == 0)), (k == 5 || k == 12));
            end
        end
    endtask

    task automatic test_err();
        logic [NCH-1:0] busy_before;
        step();
        busy_before = busy;
        set_cfg(5, 3, 1'b1, 1'b0);
        step();
        idle();
        checks++;
        if (cfg_err !== 1'b1 || busy !== busy_before || wave !== m_wave) begin
            errors++;
            $display("FAIL err_badch got e%b b%h w%h exp e1 b%h w%h", cfg_err, busy, wave, busy_before, m_wave);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err_badch_len got %b exp 0", cfg_err);
        end
        set_cfg(3, 0, 1'b1, 1'b0);
        step();
        idle();
        checks++;
        if (cfg_err !== 1'b1 || busy[3] !== 1'b0) begin
            errors++;
            $display("FAIL err_div0 got e%b b3=%b exp e1 b3=0", cfg_err, busy[3]);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (cfg_err !== 1'b0 || tick[3] !== 1'b0 || busy[3] !== 1'b0) begin
                errors++;
                $display("FAIL err_div0_after k=%0d got e%b t%b b%b exp 0 0 0", k, cfg_err, tick[3], busy[3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_cfg(k, 10 + k, 1'b1, 1'b0);
            #1;
            checks++;
            if (cfg_ready !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL b2b_ready k=%0d got %b exp %b", k, cfg_ready, (k % 2 == 0));
            end
            step();
        end
        idle();
        checks++;
        if (busy !== 4'b0101) begin
            errors++;
            $display("FAIL b2b_busy got %b exp 0101", busy);
        end
    endtask

    task automatic test_div1();
        set_cfg(1, 1, 1'b1, 1'b0);
        step();
        idle();
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (tick[1] !== 1'b1 || wave[1] !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL div1 k=%0d got t%b w%b exp t1 w%b", k, tick[1], wave[1], (k % 2 == 1));
            end
        end
    endtask

    task automatic test_clr();
        set_cfg(0, 2, 1'b1, 1'b0);
        step();
        idle();
        repeat (3) step();
        set_cfg(2, 3, 1'b1, 1'b0);
        clr = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready got %b exp 0", cfg_ready);
        end
        step();
        clr = 1'b0;
        idle();
        checks++;
        if ({tick, wave, busy} !== '0) begin
            errors++;
            $display("FAIL clr_outputs got %h exp 0", {tick, wave, busy});
        end
        step();
        checks++;
        if (busy !== '0 || cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_noxfer got b%b e%b r%b exp b0000 e0 r1", busy, cfg_err, cfg_ready);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            clr = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 2) == 0)
                set_cfg($urandom_range(0, 5), $urandom_range(0, 9), ($urandom_range(0, 4) != 0),
                        $urandom_range(0, 1) == 1);
            else
                idle();
            #1;
            checks++;
            if (cfg_ready !== (!clr && !m_hold)) begin
                errors++;
                $display("FAIL rand_ready n=%0d got %b exp %b", n, cfg_ready, (!clr && !m_hold));
            end
            step();
            checks++;
            if (tick !== m_tick || wave !== m_wave || busy !== m_run || cfg_err !== m_err) begin
                errors++;
                $display("FAIL rand n=%0d got t%b w%b b%b e%b exp t%b w%b b%b e%b", n, tick, wave, busy,
                         cfg_err, m_tick, m_wave, m_run, m_err);
            end
        end
        clr = 1'b0;
        idle();
    endtask

    task automatic test_async_reset();
        set_cfg(0, 9, 1'b1, 1'b0);
        step();
        idle();
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({tick, wave, busy, cfg_err} !== '0) begin
            errors++;
            $display("FAIL async_reset got %h exp 0", {tick, wave, busy, cfg_err});
        end
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (cfg_ready !== 1'b1 || busy !== '0) begin
            errors++;
            $display("FAIL async_reset_after got r%b b%b exp r1 b0000", cfg_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_oneshot();
        test_reconfig();
        test_err();
        test_back_to_back();
        test_div1();
        test_clr();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
